// File: rtl/peripheral.sv
// ============================================================================
//  Module      : peripheral
//  Description : Memory-mapped responder at 0x4000_00xx: reloading 32-bit
//                interval timer with IRQ, and a byte-wide UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral #(
    parameter int BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] rdata,
    output logic        irqout,
    output logic        tx
);

    localparam logic [29:0] c_word_th   = 30'h1000_0000;
    localparam logic [29:0] c_word_tl   = 30'h1000_0001;
    localparam logic [29:0] c_word_tcon = 30'h1000_0002;
    localparam logic [29:0] c_word_txd  = 30'h1000_0006;
    localparam logic [29:0] c_word_ucon = 30'h1000_0008;
    localparam logic [15:0] c_baud_last = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [7:0]  r_txd;
    logic        r_tx_done;
    logic        r_tx;
    state_t      r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;

    logic w_wr_th, w_wr_tl, w_wr_tcon, w_wr_txd, w_wr_ucon;
    logic w_busy, w_baud_end, w_frame_end, w_txd_accept;
    logic w_unused;

    assign w_wr_th   = MemWr && (addr[31:2] == c_word_th);
    assign w_wr_tl   = MemWr && (addr[31:2] == c_word_tl);
    assign w_wr_tcon = MemWr && (addr[31:2] == c_word_tcon);
    assign w_wr_txd  = MemWr && (addr[31:2] == c_word_txd);
    assign w_wr_ucon = MemWr && (addr[31:2] == c_word_ucon);
    assign w_unused  = ^addr[1:0];

    assign w_busy       = (r_state != S_IDLE);
    assign w_baud_end   = (r_baud_cnt == c_baud_last);
    assign w_frame_end  = (r_state == S_STOP) && w_baud_end;
    // The last stop-bit cycle may accept a new byte so frames can run back to back.
    assign w_txd_accept = w_wr_txd && (!w_busy || w_frame_end);

    assign irqout = r_tcon[1] & r_tcon[2];
    assign tx     = r_tx;

    always_comb begin
        rdata = 32'd0;
        if (MemRd) begin
            case (addr[31:2])
                c_word_th:   rdata = r_th;
                c_word_tl:   rdata = r_tl;
                c_word_tcon: rdata = {29'd0, r_tcon};
                c_word_txd:  rdata = {24'd0, r_txd};
                c_word_ucon: rdata = {30'd0, r_tx_done, w_busy};
                default:     rdata = 32'd0;
            endcase
        end
    end

    // Timer: a bus write to TL or TCON suppresses the whole count/overflow step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_th   <= 32'd0;
            r_tl   <= 32'd0;
            r_tcon <= 3'd0;
        end else begin
            if (w_wr_th) begin
                r_th <= wdata;
            end
            if (w_wr_tl || w_wr_tcon) begin
                if (w_wr_tl) begin
                    r_tl <= wdata;
                end
                if (w_wr_tcon) begin
                    r_tcon <= wdata[2:0];
                end
            end else if (r_tcon[0]) begin
                if (r_tl == 32'hFFFF_FFFF) begin
                    r_tl <= r_th;
                    if (r_tcon[1]) begin
                        r_tcon[2] <= 1'b1;
                    end
                end else begin
                    r_tl <= r_tl + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_txd      <= 8'd0;
            r_tx_done  <= 1'b0;
            r_tx       <= 1'b1;
            r_state    <= S_IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
        end else begin
            if (w_txd_accept) begin
                r_txd <= wdata[7:0];
            end
            if (w_frame_end) begin
                r_tx_done <= 1'b1;
            end else if (w_wr_ucon && !wdata[1]) begin
                r_tx_done <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_txd_accept) begin
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_baud_cnt <= 16'd0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= 16'd0;
                        r_bit_idx  <= 3'd0;
                        r_tx       <= r_txd[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_txd[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= 16'd0;
                        if (w_txd_accept) begin
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_peripheral.sv
// ============================================================================
//  Module      : tb_peripheral
//  Description : Self-checking bench for peripheral: timer, IRQ, UART, bus map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_peripheral;

    localparam int B = 4;
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;
    localparam logic [31:0] A_UCON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        MemRd, MemWr;
    logic [31:0] rdata;
    logic        irqout, tx;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    peripheral #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemRd(MemRd), .MemWr(MemWr), .rdata(rdata), .irqout(irqout), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file and a frame described by its start edge.
    logic [31:0] m_th = 0, m_tl = 0;
    logic [2:0]  m_tcon = 0;
    logic [7:0]  m_txd = 0;
    bit          m_done = 0, m_busy = 0;
    int          cyc = 0, m_start = 0;
    logic [31:0] wa, th0, tl0;
    logic [2:0]  tc0;
    bit          set_done;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_txd = 0; m_done = 0; m_busy = 0;
        end else begin
            wa = {addr[31:2], 2'b00};
            th0 = m_th; tl0 = m_tl; tc0 = m_tcon;
            if (MemWr && wa == A_TH) m_th = wdata;
            if (MemWr && (wa == A_TL || wa == A_TCON)) begin
                if (wa == A_TL) m_tl = wdata;
                else m_tcon = wdata[2:0];
            end else if (tc0[0]) begin
                if (tl0 == 32'hFFFF_FFFF) begin
                    m_tl = th0;
                    if (tc0[1]) m_tcon[2] = 1'b1;
                end else begin
                    m_tl = tl0 + 1;
                end
            end
            set_done = 0;
            if (m_busy && (cyc - m_start) == 10 * B) begin
                m_busy = 0; m_done = 1; set_done = 1;
            end
            if (MemWr && wa == A_TXD && !m_busy) begin
                m_busy = 1; m_start = cyc; m_txd = wdata[7:0];
            end
            if (MemWr && wa == A_UCON && !wdata[1] && !set_done) m_done = 0;
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
        if (!rd) return 32'd0;
        case ({a[31:2], 2'b00})
            A_TH:    return m_th;
            A_TL:    return m_tl;
            A_TCON:  return {29'd0, m_tcon};
            A_TXD:   return {24'd0, m_txd};
            A_UCON:  return {30'd0, m_done, m_busy};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_tx();
        int b;
        if (!m_busy) return 1'b1;
        b = (cyc - m_start) / B;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_txd[b-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata", rdata, model_read(addr, MemRd));
            check("irqout", {31'd0, irqout}, {31'd0, m_tcon[1] & m_tcon[2]});
            check("tx", {31'd0, tx}, {31'd0, exp_tx()});
        end
    end

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWr = 1'b1;
        @(posedge clk); #1;
        MemWr = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; MemRd = 1'b1;
        @(negedge clk);
        check(name, rdata, exp);
        @(posedge clk); #1;
        MemRd = 1'b0;
    endtask

    logic [9:0] pat;

    initial begin
        reset = 1'b0; addr = 0; wdata = 0; MemRd = 0; MemWr = 0;
        pat = {1'b1, 8'hA5, 1'b0};
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irqout}, 32'd0);
        @(posedge clk); #1;
        read_chk("rst_th", A_TH, 32'd0);
        read_chk("rst_tl", A_TL, 32'd0);
        read_chk("rst_tcon", A_TCON, 32'd0);
        read_chk("rst_txd", A_TXD, 32'd0);
        read_chk("rst_ucon", A_UCON, 32'd0);

        write(A_TH, 32'h1234_5678);
        read_chk("th_alias", 32'h4000_0003, 32'h1234_5678);
        write(32'h4000_000C, 32'hDEAD_BEEF);
        read_chk("unmapped_lo", 32'h4000_000C, 32'd0);
        read_chk("unmapped_hi", 32'h5000_0000, 32'd0);

        // Timer reload and IRQ
        write(A_TH, 32'hFFFF_FFFC);
        write(A_TL, 32'hFFFF_FFFC);
        write(A_TCON, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        addr = A_TL; MemRd = 1'b1;
        @(negedge clk);
        check("tl_max", rdata, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        check("tl_reload", rdata, 32'hFFFF_FFFC);
        check("irq_set", {31'd0, irqout}, 32'd1);
        #1 addr = A_TCON;
        #1 check("tcon_7", rdata, 32'd7);
        @(posedge clk); #1;
        MemRd = 1'b0;
        write(A_TCON, 32'd3);
        @(negedge clk);
        check("irq_clear", {31'd0, irqout}, 32'd0);
        @(posedge clk); #1;

        // Bus write to TL lands in the overflow cycle
        write(A_TL, 32'hFFFF_FFFD);
        repeat (2) @(posedge clk);
        #1;
        write(A_TL, 32'h10);
        read_chk("tl_prio", A_TL, 32'h10);
        read_chk("tcon_prio", A_TCON, 32'd3);
        write(A_TCON, 32'd0);

        // UART frame 0xA5, with a dropped write mid-frame
        write(A_TXD, 32'hA5);
        for (int i = 0; i < 10 * B; i++) begin
            @(negedge clk);
            check("tx_bit", {31'd0, tx}, {31'd0, pat[i / B]});
            if (i == 21) check("txd_keep", rdata, 32'hA5);
            if (i == 31) check("ucon_busy", rdata, 32'd1);
            @(posedge clk); #1;
            MemWr = 1'b0; MemRd = 1'b0;
            if (i == 11) begin addr = A_TXD; wdata = 32'h5A; MemWr = 1'b1; end
            if (i == 20) begin addr = A_TXD; MemRd = 1'b1; end
            if (i == 30) begin addr = A_UCON; MemRd = 1'b1; end
        end
        read_chk("ucon_done", A_UCON, 32'd2);
        write(A_UCON, 32'd0);
        read_chk("ucon_clr", A_UCON, 32'd0);

        // Back-to-back frames
        write(A_TXD, 32'h3C);
        repeat (10 * B - 1) @(posedge clk);
        #1;
        write(A_TXD, 32'hC3);
        addr = A_UCON; MemRd = 1'b1;
        @(negedge clk);
        check("b2b_ucon", rdata, 32'd3);
        check("b2b_tx", {31'd0, tx}, 32'd0);
        @(posedge clk); #1;
        MemRd = 1'b0;
        read_chk("b2b_txd", A_TXD, 32'hC3);

        // Reset during the data bits
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        addr = A_UCON; MemRd = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_ucon", rdata, 32'd0);
        @(posedge clk); #1;
        MemRd = 1'b0;
        read_chk("mid_rst_txd", A_TXD, 32'd0);
        repeat (10 * B + 5) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got none expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
